// File: rtl/bullet_fire_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bullet_fire_controller: frame-paced bullet slot allocator and launcher      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module bullet_fire_controller #(
  parameter int NUM_SLOTS       = 6,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int SCREEN_H        = 480
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 VS,
  input  logic                 shootingEnable,
  input  logic                 direction,
  input  logic [9:0]           PlayerX,
  input  logic [9:0]           PlayerY,
  input  logic [9:0]           PlayerWidth,
  input  logic [9:0]           PlayerHeight,
  input  logic [NUM_SLOTS-1:0] slot_done,
  output logic [NUM_SLOTS-1:0] spawn,
  output logic [9:0]           spawnX,
  output logic [9:0]           spawnY,
  output logic                 spawnDir,
  output logic [NUM_SLOTS-1:0] active,
  output logic                 cooldown_busy
);

  localparam logic [7:0]  COOLDOWN_INIT = 8'(COOLDOWN_FRAMES);
  localparam logic [10:0] Y_MAX         = 11'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FIRE     = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  state_t               state_q;
  logic                 vs_meta_q, vs_sync_q, vs_prev_q;
  logic [7:0]           cnt_q;
  logic [NUM_SLOTS-1:0] active_q, active_d;
  logic [NUM_SLOTS-1:0] spawn_q;
  logic [9:0]           spawn_x_q, spawn_y_q;
  logic                 spawn_dir_q;
  logic                 busy_q;

  logic                 tick;
  logic                 fire_go;
  logic [NUM_SLOTS-1:0] free_onehot;
  logic [10:0]          x_sum, y_sum;
  logic [9:0]           x_launch, y_launch;

  assign tick    = vs_sync_q & ~vs_prev_q;
  assign fire_go = tick & shootingEnable & ~(&active_q) & (state_q == S_IDLE);

  // Downward scan so the last hit written is the lowest free index.
  always_comb begin
    free_onehot = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (!active_q[k]) begin
        free_onehot    = '0;
        free_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    x_sum = {1'b0, PlayerX} + {1'b0, PlayerWidth};
    y_sum = {1'b0, PlayerY} + {1'b0, (PlayerHeight >> 1)};
    if (direction)
      x_launch = x_sum[10] ? 10'h3FF : x_sum[9:0];
    else
      x_launch = (PlayerX == 10'd0) ? 10'd0 : PlayerX - 10'd1;
    y_launch = (y_sum > Y_MAX) ? Y_MAX[9:0] : y_sum[9:0];
  end

  // A newly launched slot is set after the retire mask, so set wins a collision.
  assign active_d = (active_q & ~slot_done) | spawn_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      vs_meta_q   <= 1'b0;
      vs_sync_q   <= 1'b0;
      vs_prev_q   <= 1'b0;
      cnt_q       <= 8'd0;
      active_q    <= '0;
      spawn_q     <= '0;
      spawn_x_q   <= 10'd0;
      spawn_y_q   <= 10'd0;
      spawn_dir_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      vs_meta_q <= VS;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
      active_q  <= active_d;
      spawn_q   <= '0;
      case (state_q)
        S_IDLE: begin
          if (fire_go) begin
            state_q     <= S_FIRE;
            spawn_q     <= free_onehot;
            spawn_x_q   <= x_launch;
            spawn_y_q   <= y_launch;
            spawn_dir_q <= direction;
          end
        end
        S_FIRE: begin
          if (COOLDOWN_INIT == 8'd0) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_COOLDOWN;
            cnt_q   <= COOLDOWN_INIT;
            busy_q  <= 1'b1;
          end
        end
        S_COOLDOWN: begin
          if (tick) begin
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q <= 8'd1) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign spawn         = spawn_q;
  assign spawnX        = spawn_x_q;
  assign spawnY        = spawn_y_q;
  assign spawnDir      = spawn_dir_q;
  assign active        = active_q;
  assign cooldown_busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bullet_fire_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bullet_fire_controller: directed vectors and multi-frame sequences       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_bullet_fire_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       VS = 1'b0;
  logic       shootingEnable = 1'b0;
  logic       direction = 1'b0;
  logic [9:0] PlayerX = '0, PlayerY = '0, PlayerWidth = '0, PlayerHeight = '0;
  logic [5:0] slot_done = '0;
  logic [5:0] spawn, active;
  logic [9:0] spawnX, spawnY;
  logic       spawnDir, cooldown_busy;

  int checks = 0;
  int errors = 0;

  bullet_fire_controller #(
    .NUM_SLOTS(6), .COOLDOWN_FRAMES(8), .SCREEN_H(480)
  ) dut (
    .Clk(Clk), .Reset(Reset), .VS(VS), .shootingEnable(shootingEnable),
    .direction(direction), .PlayerX(PlayerX), .PlayerY(PlayerY),
    .PlayerWidth(PlayerWidth), .PlayerHeight(PlayerHeight), .slot_done(slot_done),
    .spawn(spawn), .spawnX(spawnX), .spawnY(spawnY), .spawnDir(spawnDir),
    .active(active), .cooldown_busy(cooldown_busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       dir;
    logic [9:0] px, pw, py, ph;
    logic [9:0] ex, ey;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b0;
    VS = 1'b0;
    slot_done = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
  endtask

  // One VS frame; done_mask is driven on slot_done during the tick cycle.
  task automatic do_frame(input logic [5:0] done_mask, output logic [5:0] seen,
                          output int first, output int width);
    seen = '0;
    first = 0;
    width = 0;
    @(negedge Clk);
    VS = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge Clk);
      #1;
      if (spawn != 6'd0) begin
        seen |= spawn;
        width++;
        if (first == 0) first = i;
      end
      if (i == 2) slot_done = done_mask;
      if (i == 3) slot_done = '0;
    end
    @(negedge Clk);
    VS = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic pulse_done(input logic [5:0] m);
    @(negedge Clk);
    slot_done = m;
    @(negedge Clk);
    slot_done = '0;
    @(negedge Clk);
  endtask

  initial begin
    logic [5:0] seen;
    int first, width;
    logic [5:0] exp_seen;

    vecs[0] = '{1'b1, 10'd100,  10'd20,   10'd200, 10'd40,   10'd120,  10'd220};
    vecs[1] = '{1'b0, 10'd0,    10'd5,    10'd470, 10'd40,   10'd0,    10'd479};
    vecs[2] = '{1'b0, 10'd50,   10'd9,    10'd10,  10'd7,    10'd49,   10'd13};
    vecs[3] = '{1'b1, 10'd1000, 10'd50,   10'd0,   10'd0,    10'd1023, 10'd0};
    vecs[4] = '{1'b1, 10'd1023, 10'd1023, 10'd479, 10'd1,    10'd1023, 10'd479};
    vecs[5] = '{1'b0, 10'd1023, 10'd3,    10'd1023, 10'd1023, 10'd1022, 10'd479};
    vecs[6] = '{1'b1, 10'd0,    10'd0,    10'd478, 10'd2,    10'd0,    10'd479};
    vecs[7] = '{1'b1, 10'd973,  10'd50,   10'd100, 10'd1023, 10'd1023, 10'd479};

    // Reset state and no spawn without a request
    do_reset();
    #1;
    check("rst_spawn", 32'(spawn), 0);
    check("rst_active", 32'(active), 0);
    check("rst_spawnX", 32'(spawnX), 0);
    check("rst_spawnY", 32'(spawnY), 0);
    check("rst_spawnDir", 32'(spawnDir), 0);
    check("rst_busy", 32'(cooldown_busy), 0);
    for (int f = 0; f < 3; f++) begin
      do_frame(6'd0, seen, first, width);
      check("idle_no_spawn", 32'(seen), 0);
    end

    // Launch-data vectors, each from a fresh reset
    for (int v = 0; v < 8; v++) begin
      do_reset();
      shootingEnable = 1'b1;
      direction = vecs[v].dir;
      PlayerX = vecs[v].px;
      PlayerWidth = vecs[v].pw;
      PlayerY = vecs[v].py;
      PlayerHeight = vecs[v].ph;
      do_frame(6'd0, seen, first, width);
      check($sformatf("v%0d_spawn", v), 32'(seen), 32'h1);
      check($sformatf("v%0d_latency", v), 32'(first), 3);
      check($sformatf("v%0d_width", v), 32'(width), 1);
      check($sformatf("v%0d_spawnX", v), 32'(spawnX), 32'(vecs[v].ex));
      check($sformatf("v%0d_spawnY", v), 32'(spawnY), 32'(vecs[v].ey));
      check($sformatf("v%0d_spawnDir", v), 32'(spawnDir), 32'(vecs[v].dir));
      check($sformatf("v%0d_active", v), 32'(active), 32'h1);
      check($sformatf("v%0d_busy", v), 32'(cooldown_busy), 1);
    end

    // Held request for 60 frames: one shot per 9 frames until the pool fills
    do_reset();
    direction = 1'b1;
    PlayerX = 10'd100; PlayerWidth = 10'd20; PlayerY = 10'd200; PlayerHeight = 10'd40;
    shootingEnable = 1'b1;
    for (int f = 0; f < 60; f++) begin
      do_frame(6'd0, seen, first, width);
      exp_seen = ((f % 9) == 0 && (f / 9) < 6) ? 6'(1 << (f / 9)) : 6'd0;
      check($sformatf("hold_f%0d", f), 32'(seen), 32'(exp_seen));
    end
    check("full_active", 32'(active), 32'h3F);
    check("full_no_cooldown", 32'(cooldown_busy), 0);
    check("hold_spawnX", 32'(spawnX), 120);

    // Retire from a full pool; a second retire on the freed slot is ignored
    pulse_done(6'b001000);
    check("retire3_active", 32'(active), 32'h37);
    pulse_done(6'b001000);
    check("retire3_again", 32'(active), 32'h37);
    do_frame(6'd0, seen, first, width);
    check("refill_slot3", 32'(seen), 32'h08);
    check("refill_active", 32'(active), 32'h3F);
    for (int f = 0; f < 8; f++) do_frame(6'd0, seen, first, width);
    check("cooldown_done", 32'(cooldown_busy), 0);

    // Slot freed during the tick cycle is not usable on that tick
    do_frame(6'b000010, seen, first, width);
    check("tick_free_no_spawn", 32'(seen), 0);
    check("tick_free_active", 32'(active), 32'h3D);
    check("tick_free_no_busy", 32'(cooldown_busy), 0);
    do_frame(6'd0, seen, first, width);
    check("next_tick_slot1", 32'(seen), 32'h02);
    check("next_tick_active", 32'(active), 32'h3F);

    // Asynchronous reset in the middle of a cooldown
    do_reset();
    direction = 1'b0;
    PlayerX = 10'd0; PlayerY = 10'd470; PlayerHeight = 10'd40;
    for (int f = 0; f < 21; f++) do_frame(6'd0, seen, first, width);
    check("pre_rst_active", 32'(active), 32'h07);
    check("pre_rst_busy", 32'(cooldown_busy), 1);
    check("pre_rst_spawnX", 32'(spawnX), 0);
    check("pre_rst_spawnY", 32'(spawnY), 479);
    @(negedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    check("async_rst_active", 32'(active), 0);
    check("async_rst_busy", 32'(cooldown_busy), 0);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    do_frame(6'd0, seen, first, width);
    check("post_rst_slot0", 32'(seen), 32'h01);
    check("post_rst_active", 32'(active), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
